// File: rtl/arm_pkg.sv
// Shared encodings for the single-cycle ARM core: opcodes, funct/class/shift fields,
// loader FSM states and a word-packing helper.
package arm_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_ORR = 4'd3,
    OP_CMP = 4'd4,
    OP_LSL = 4'd5,
    OP_LSR = 4'd6,
    OP_STR = 4'd7,
    OP_LDR = 4'd8
  } opcode_e;

  localparam logic [5:0] FN_ADD   = 6'b001000;
  localparam logic [5:0] FN_SUB   = 6'b000100;
  localparam logic [5:0] FN_AND   = 6'b000000;
  localparam logic [5:0] FN_ORR   = 6'b011000;
  localparam logic [5:0] FN_CMP   = 6'b010101;
  localparam logic [5:0] FN_SHIFT = 6'b011010;
  localparam logic [5:0] FN_STR   = 6'b011000;
  localparam logic [5:0] FN_LDR   = 6'b011001;

  localparam logic [1:0] CLS_DP  = 2'b00;
  localparam logic [1:0] CLS_MEM = 2'b01;
  localparam logic [1:0] SH_LSL  = 2'b00;
  localparam logic [1:0] SH_LSR  = 2'b01;

  localparam logic [3:0] COND_AL = 4'b1110;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_WRITE,
    ST_RUN
  } state_e;

  // Layout: [31:28] cond, [27:26] class, [25:20] funct, [19:16] Rn, [15:12] Rd, [11:0] low
  function automatic logic [31:0] pack_word(input logic [3:0]  cond,
                                            input logic [1:0]  cls,
                                            input logic [5:0]  fn,
                                            input logic [3:0]  rn,
                                            input logic [3:0]  rd,
                                            input logic [11:0] low);
    return {cond, cls, fn, rn, rd, low};
  endfunction

endpackage

// File: rtl/arm_instr_encode.sv
// Combinational encoder: mnemonic-level request to the 32-bit word the core decodes.
module arm_instr_encode
  import arm_pkg::*;
#(
  parameter logic [3:0] COND = COND_AL
) (
  input  logic [3:0]  op_i,
  input  logic [3:0]  rd_i,
  input  logic [3:0]  rn_i,
  input  logic [3:0]  rm_i,
  input  logic [11:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD: word_o = pack_word(COND, CLS_DP, FN_ADD, rn_i, rd_i, {8'h00, rm_i});
      OP_SUB: word_o = pack_word(COND, CLS_DP, FN_SUB, rn_i, rd_i, {8'h00, rm_i});
      OP_AND: word_o = pack_word(COND, CLS_DP, FN_AND, rn_i, rd_i, {8'h00, rm_i});
      OP_ORR: word_o = pack_word(COND, CLS_DP, FN_ORR, rn_i, rd_i, {8'h00, rm_i});
      OP_CMP: word_o = pack_word(COND, CLS_DP, FN_CMP, rn_i, 4'h0, {8'h00, rm_i});
      // Shifts: Rn forced to 0, amount in [11:7], shift type in [6:5]
      OP_LSL: word_o = pack_word(COND, CLS_DP, FN_SHIFT, 4'h0, rd_i,
                                 {imm_i[4:0], SH_LSL, 1'b0, rm_i});
      OP_LSR: word_o = pack_word(COND, CLS_DP, FN_SHIFT, 4'h0, rd_i,
                                 {imm_i[4:0], SH_LSR, 1'b0, rm_i});
      OP_STR: word_o = pack_word(COND, CLS_MEM, FN_STR, rn_i, rd_i, imm_i);
      OP_LDR: word_o = pack_word(COND, CLS_MEM, FN_LDR, rn_i, rd_i, imm_i);
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/arm_instr_loader.sv
// Loads encoded instructions into instruction memory one word per two cycles,
// holding the core in reset until the last word (or memory end) is written.
module arm_instr_loader
  import arm_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter logic [3:0]  COND   = COND_AL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rm,
  input  logic [11:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic              overflow,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic [31:0]       enc_word;
  logic              enc_illegal;

  arm_instr_encode #(.COND(COND)) u_encode (
    .op_i      (in_op),
    .rd_i      (in_rd),
    .rn_i      (in_rn),
    .rm_i      (in_rm),
    .imm_i     (in_imm),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          if (enc_illegal) begin
            err_d = 1'b1;
          end else begin
            wdata_d = enc_word;
            last_d  = in_last;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        count_d = count_q + (ADDR_W+1)'(1);
        // Address holds at the top word so it never rolls back to 0 without rst
        if (addr_q != ADDR_MAX) addr_d = addr_q + ADDR_W'(1);
        if (last_q) begin
          state_d = ST_RUN;
        end else if (addr_q == ADDR_MAX) begin
          ovf_d   = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_LOAD;
    endcase
    // Outputs decoded from the next state so they leave the block straight from flops
    ready_d   = (state_d == ST_LOAD);
    we_d      = (state_d == ST_WRITE);
    done_d    = (state_d == ST_RUN);
    cpu_rst_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      ready_q   <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      last_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      last_q    <= last_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
    end
  end

  assign in_ready   = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;
  assign overflow   = ovf_q;
  assign count      = count_q;

endmodule

// File: doc/arm_instr_loader.md
# arm_instr_loader

Instruction encoder and loader for the single-cycle ARM core: accepts mnemonic-level instruction requests over a valid/ready handshake, encodes each into the 32-bit word layout the core's decoder expects, and writes the words sequentially into instruction memory. It holds the core in reset during loading and releases it after the last word is written. It sits between the test/boot source and the datapath's instruction-memory write port, driving the encoding side of the decoder's field layout.

## Interface
- ADDR_W, 6, instruction-memory word-address width (2^ADDR_W words)
- COND, 4'b1110, condition field placed in bits [31:28] of every word
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request this cycle
- in_op  in  4  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 CMP, 5 LSL, 6 LSR, 7 STR, 8 LDR; 9–15 illegal
- in_rd / in_rn / in_rm  in  4 each  register fields
- in_imm  in  12  STR/LDR offset; LSL/LSR shift amount in in_imm[4:0]
- in_last  in  1  final instruction of the program
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address of the current write
- imem_wdata  out  32  encoded instruction
- cpu_rst  out  1  core reset; high while loading
- done  out  1  program loaded, core running
- err  out  1  sticky: illegal op received
- overflow  out  1  sticky: memory filled before in_last
- count  out  ADDR_W+1  number of words written

## Operation
- Common fields: [31:28]=COND, [19:16]=Rn, [15:12]=Rd, [3:0]=Rm, other bits 0 unless listed.
- [27:26]=00 with [25:20]: ADD 001000, SUB 000100, AND 000000, ORR 011000, CMP 010101 (Rd forced to 0), LSL/LSR 011010 (Rn forced to 0, [11:7]=in_imm[4:0], [6:5]=00 LSL / 01 LSR).
- [27:26]=01 with [25:20]: STR 011000, LDR 011001; [11:0]=in_imm, Rm field not used.
- FSM states:
  - LOAD: in_ready=1. On handshake with a legal op, register the encoded word and go to WRITE. On an illegal op, set err, write nothing, and stay in LOAD. in_last is ignored for illegal ops.
  - WRITE: imem_we=1, in_ready=0. At the edge, increment imem_addr and count. If the captured in_last was set, go to RUN. Else, if imem_addr was 2^ADDR_W−1, set overflow and go to RUN. Otherwise go to LOAD.
  - RUN: cpu_rst=0, done=1, in_ready=0, inputs ignored. Exit only through rst.
- imem_addr wraps only via rst; a write never occurs to address 0 twice without rst.

## Timing
- All outputs registered. Reset values: state LOAD, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, done=0, err=0, overflow=0, count=0.
- Write latency:
  - Handshake at edge N.
  - imem_we high in the cycle after edge N, with imem_addr and imem_wdata valid.
  - in_ready is high again after edge N+1.
  - Throughput is 1 word per 2 cycles.
- Last word: cpu_rst falls and done rises at the same edge that ends the final WRITE cycle.
- in_valid held high while in_ready=0 is ignored; the request is not consumed.
- rst mid-load: the next cycle is LOAD with all reset values. Partially written memory contents are not cleared.

## Structure
- Shared package arm_pkg:
  - opcode enum (values above)
  - 6-bit funct constants: FN_ADD, FN_SUB, FN_AND, FN_ORR, FN_CMP, FN_SHIFT, FN_STR, FN_LDR
  - class constants CLS_DP=2'b00, CLS_MEM=2'b01
  - shift-type constants SH_LSL=2'b00, SH_LSR=2'b01
  - COND_AL=4'b1110
- One combinational sub-module arm_instr_encode: takes op/rd/rn/rm/imm and produces word plus illegal. The FSM lives in the top.

## Test plan
- Reset, then ADD rd=3 rn=1 rm=2 with in_last=0 → imem_we one cycle later at addr 0, wdata 0xE0813002; in_ready low for exactly 1 cycle.
- Back-to-back SUB 4,5,6; CMP rn=1 rm=2; LSL rd=2 rm=7 imm=3; LSR same operands → addrs 1–4 receive 0xE0454006, 0xE1510002, 0xE1A02187, 0xE1A021A7.
- STR rd=1 rn=2 imm=8, then LDR rd=1 rn=2 imm=8 with in_last=1 → 0xE5821008 then 0xE5921008. After the final write: cpu_rst=0, done=1, count=2, in_ready=0.
- op=12 offered → no imem_we, err=1 and stays set. The next legal op is written at the unchanged address.
- ADDR_W=2, four legal ops with in_last=0 → fourth write at addr 3, then overflow=1, done=1, count=4.
- rst asserted during a WRITE cycle → next cycle imem_we=0, imem_addr=0, cpu_rst=1, count=0, err=0, in_ready=1.
